// File: rtl/traffic_conflict_monitor.sv
// Two-approach traffic lamp conflict monitor.
// The lamp drives are sampled once, and each approach has a phase tracker.
// The first fault to occur is latched with a 3-bit code, and a flashing-red
// enable is produced while the fault is set.
// Optional feature: TLC_WATCHDOG_EN adds a stuck-lamp watchdog that reports code 6.
module traffic_conflict_monitor #(
    parameter int unsigned YELLOW_MIN = 3,
    parameter int unsigned GREEN_MIN  = 5,
    parameter int unsigned STUCK_MAX  = 1000,
    parameter int unsigned FLASH_DIV  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Ra,
    input  logic       Ya,
    input  logic       Ga,
    input  logic       Rb,
    input  logic       Yb,
    input  logic       Gb,
    input  logic       fault_clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash
);
    typedef enum logic [1:0] {PhRed = 2'd0, PhGreen = 2'd1, PhYellow = 2'd2} phase_e;

    localparam logic [7:0] YellowMin = 8'(YELLOW_MIN);
    localparam logic [7:0] GreenMin  = 8'(GREEN_MIN);
    localparam logic [7:0] FlashLast = 8'(FLASH_DIV - 1);

    // Index 0 is approach A and index 1 is approach B. Lamp bits are ordered {R, Y, G}.
    logic [2:0] lamp_d  [2];
    logic [2:0] lamp_q  [2];
    phase_e     seen    [2];
    phase_e     phase_d [2];
    phase_e     phase_q [2];
    logic [7:0] cnt_d   [2];
    logic [7:0] cnt_q   [2];
    logic [1:0] enc_ok, yel_short, grn_short, illegal;
    logic       conflict, stuck;
    logic [2:0] cond_code;
    logic       fault_d, fault_q, flash_d, flash_q;
    logic [2:0] code_d, code_q;
    logic [7:0] div_d, div_q;

    assign lamp_d[0] = {Ra, Ya, Ga};
    assign lamp_d[1] = {Rb, Yb, Gb};

    // Sample stage, phase trackers and the fault and flash state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                lamp_q[i]  <= 3'b100;
                phase_q[i] <= PhRed;
                cnt_q[i]   <= 8'd1;
            end
            fault_q <= 1'b0;
            code_q  <= 3'd0;
            flash_q <= 1'b0;
            div_q   <= 8'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                lamp_q[i]  <= lamp_d[i];
                phase_q[i] <= phase_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            fault_q <= fault_d;
            code_q  <= code_d;
            flash_q <= flash_d;
            div_q   <= div_d;
        end
    end

    // Tracker next state and transition checks. A malformed lamp set holds the tracker.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            enc_ok[i]    = $onehot(lamp_q[i]);
            seen[i]      = lamp_q[i][2] ? PhRed : (lamp_q[i][1] ? PhYellow : PhGreen);
            phase_d[i]   = phase_q[i];
            cnt_d[i]     = cnt_q[i];
            yel_short[i] = 1'b0;
            grn_short[i] = 1'b0;
            illegal[i]   = 1'b0;
            if (enc_ok[i]) begin
                if (seen[i] != phase_q[i]) begin
                    // The tracker follows the lamps, even after an illegal jump.
                    phase_d[i] = seen[i];
                    cnt_d[i]   = 8'd1;
                    unique case (phase_q[i])
                        PhRed:    illegal[i] = (seen[i] != PhGreen);
                        PhGreen: begin
                            illegal[i]   = (seen[i] != PhYellow);
                            grn_short[i] = !illegal[i] && (cnt_q[i] < GreenMin);
                        end
                        PhYellow: begin
                            illegal[i]   = (seen[i] != PhRed);
                            yel_short[i] = !illegal[i] && (cnt_q[i] < YellowMin);
                        end
                        default:  illegal[i] = 1'b1;
                    endcase
                end else if (cnt_q[i] != 8'hFF) begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end
        end
    end

    // A conflict means both approaches show a yellow or green lamp.
    assign conflict = (|lamp_q[0][1:0]) & (|lamp_q[1][1:0]);

`ifdef TLC_WATCHDOG_EN
    localparam logic [15:0] StuckMax = 16'(STUCK_MAX);

    logic [5:0]  prev_q;
    logic [15:0] wd_d, wd_q;
    logic        unchanged;

    assign unchanged = ({lamp_q[0], lamp_q[1]} == prev_q);

    // Counts consecutive sampled cycles with no lamp change, saturating at the maximum.
    always_comb begin
        wd_d = 16'd0;
        if (unchanged) begin
            wd_d = (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;
        end
    end

    assign stuck = unchanged && (wd_d >= StuckMax);

    // Holds the previous lamp sample and the watchdog count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 6'b100100;
            wd_q   <= 16'd0;
        end else begin
            prev_q <= {lamp_q[0], lamp_q[1]};
            wd_q   <= wd_d;
        end
    end
`else
    assign stuck = 1'b0;
`endif

    // When several fault conditions occur together, the lowest code is chosen.
    always_comb begin
        cond_code = 3'd0;
        if (conflict)          cond_code = 3'd1;
        else if (!enc_ok[0])   cond_code = 3'd2;
        else if (!enc_ok[1])   cond_code = 3'd3;
        else if (|yel_short)   cond_code = 3'd4;
        else if (|grn_short)   cond_code = 3'd5;
        else if (stuck)        cond_code = 3'd6;
        else if (|illegal)     cond_code = 3'd7;
    end

    // Fault latch with clear, and the flash divider that runs only while a fault is set.
    always_comb begin
        fault_d = fault_q;
        code_d  = code_q;
        flash_d = 1'b0;
        div_d   = 8'd0;
        if (!fault_q) begin
            if (cond_code != 3'd0) begin
                fault_d = 1'b1;
                code_d  = cond_code;
            end
        end else if (fault_clr) begin
            // A clear in the same cycle as a new condition reloads the code instead.
            fault_d = (cond_code != 3'd0);
            code_d  = cond_code;
        end
        if (fault_d) begin
            if (!fault_q) begin
                flash_d = 1'b1;
            end else if (div_q == FlashLast) begin
                flash_d = !flash_q;
            end else begin
                flash_d = flash_q;
                div_d   = div_q + 8'd1;
            end
        end
    end

    assign fault      = fault_q;
    assign fault_code = code_q;
    assign flash      = flash_q;
endmodule
